ps2_kbd_rx: RTL

Parametrised PS/2 keyboard receiver for the I/O subsystem. It runs on a single system clock and samples the raw ps2_clk and ps2_data lines through a synchroniser and glitch filter. A framing FSM with timeout recovery assembles each byte, and an optional decoder folds the E0/F0 prefix bytes into flags. Decoded codes are buffered in a show-ahead FIFO for CPU reads, with full-depth occupancy, level reporting and error statistics.

---
 rtl/ps2_kbd_rx_if.sv | 22 ++
 rtl/ps2_kbd_rx.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_rx_if.sv
// CPU-side read port of the PS/2 keyboard receiver: pop strobe, show-ahead head and status.
interface ps2_kbd_rx_if #(
  parameter int FIFO_AW = 3
);
  logic               rdn;
  logic [9:0]         data;
  logic               ready;
  logic [FIFO_AW:0]   level;
  logic               overflow;
  logic               frame_err;
  logic [7:0]         err_count;

  modport master (
    output rdn,
    input  data, ready, level, overflow, frame_err, err_count
  );

  modport slave (
    input  rdn,
    output data, ready, level, overflow, frame_err, err_count
  );
endinterface

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: sync + glitch filter, framing FSM with timeout, E0/F0 prefix folding,
// show-ahead FIFO with level, sticky overflow/frame error flags and a saturating error counter.
module ps2_kbd_rx #(
  parameter int FIFO_AW        = 3,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int DECODE         = 1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  ps2_kbd_rx_if.slave   bus
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic                clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic                filt_q, filt_d;
  logic [3:0]          fcnt_q, fcnt_d;
  state_t              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [7:0]          shift_q, shift_d;
  logic                par_q, par_d;
  logic [TW-1:0]       to_q, to_d;
  logic                ext_q, ext_d, brk_q, brk_d;
  logic [9:0]          mem_q [DEPTH];
  logic [FIFO_AW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [FIFO_AW:0]    level_q, level_d;
  logic                ovf_q, ovf_d, ferr_q, ferr_d;
  logic [7:0]          errc_q, errc_d;
  logic                strobe, byte_vld, err_evt, push_vld, push_ok, pop;
  logic [9:0]          push_dat;

  always_comb begin
    // The filtered clock only follows the synchronised line after FILTER_LEN differing samples.
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == 4'(FILTER_LEN - 1)) filt_d = clk_s2_q;
      else                              fcnt_d = fcnt_q + 4'd1;
    end
    strobe = filt_q & ~filt_d;

    state_d  = state_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    par_d    = par_q;
    byte_vld = 1'b0;
    err_evt  = 1'b0;
    to_d     = (state_q == IDLE) ? '0 : to_q + TW'(1);
    if (strobe) begin
      to_d = '0;
      unique case (state_q)
        IDLE: if (!dat_s2_q) begin
          state_d = DATA;
          idx_d   = '0;
        end
        DATA: begin
          shift_d = {dat_s2_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_s2_q;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (dat_s2_q && (^{shift_q, par_q})) byte_vld = 1'b1;
          else                                  err_evt  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && to_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d = IDLE;
      to_d    = '0;
      err_evt = 1'b1;
    end

    ext_d    = ext_q;
    brk_d    = brk_q;
    push_vld = 1'b0;
    push_dat = {ext_q, brk_q, shift_q};
    if (err_evt) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_vld) begin
      if (DECODE == 0) begin
        push_vld = 1'b1;
        push_dat = {2'b00, shift_q};
      end else if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        push_vld = 1'b1;
        ext_d    = 1'b0;
        brk_d    = 1'b0;
      end
    end

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
    pop     = !bus.rdn && (level_q != '0);
    push_ok = push_vld && (!level_q[FIFO_AW] || pop);
    wr_d    = push_ok ? wr_q + FIFO_AW'(1) : wr_q;
    rd_d    = pop ? rd_q + FIFO_AW'(1) : rd_q;
    unique case ({push_ok, pop})
      2'b10:   level_d = level_q + (FIFO_AW + 1)'(1);
      2'b01:   level_d = level_q - (FIFO_AW + 1)'(1);
      default: level_d = level_q;
    endcase

    ovf_d  = (ovf_q & ~pop) | (push_vld & ~push_ok);
    ferr_d = (ferr_q & ~pop) | err_evt;
    errc_d = (err_evt && errc_q != 8'hFF) ? errc_q + 8'd1 : errc_q;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      filt_q   <= 1'b1;
      fcnt_q   <= '0;
      state_q  <= IDLE;
      idx_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      to_q     <= '0;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      wr_q     <= '0;
      rd_q     <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      ferr_q   <= 1'b0;
      errc_q   <= '0;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
      state_q  <= state_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      to_q     <= to_d;
      ext_q    <= ext_d;
      brk_q    <= brk_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      ferr_q   <= ferr_d;
      errc_q   <= errc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= push_dat;
  end

  assign bus.data      = mem_q[rd_q];
  assign bus.ready     = (level_q != '0);
  assign bus.level     = level_q;
  assign bus.overflow  = ovf_q;
  assign bus.frame_err = ferr_q;
  assign bus.err_count = errc_q;
endmodule
